// File: rtl/com_fw_to_dut_arb_pkg.sv
// rtl/com_fw_to_dut_arb_pkg.sv - shared types and pin map for the firmware-to-DUT arbiter
package com_fw_to_dut_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GUARD  = 2'd1,
        ACTIVE = 2'd2
    } arb_state_t;

    // DUT output pin indices
    localparam int PIN_SUPER_PIXEL_SEL   = 0;
    localparam int PIN_CONFIG_CLK        = 1;
    localparam int PIN_RESET_NOT         = 2;
    localparam int PIN_CONFIG_IN         = 3;
    localparam int PIN_CONFIG_LOAD       = 4;
    localparam int PIN_BXCLK_ANA         = 5;
    localparam int PIN_BXCLK             = 6;
    localparam int PIN_VIN_TEST_TRIG_OUT = 7;
    localparam int PIN_SCAN_IN           = 8;
    localparam int PIN_SCAN_LOAD         = 9;

    // DUT input pin indices
    localparam int PIN_CONFIG_OUT        = 0;
    localparam int PIN_SCAN_OUT          = 1;
    localparam int PIN_SYNC_OUT          = 2;
    localparam int PIN_UP_EVENT_TOGGLE   = 3;
    localparam int PIN_DN_EVENT_TOGGLE   = 4;

    // Safe levels: chip held out of reset with config load inactive
    localparam logic [9:0] ARB_OUT_DEFAULT =
        (10'b1 << PIN_RESET_NOT) | (10'b1 << PIN_CONFIG_LOAD);

    // Clocks that always belong to one dedicated firmware IP
    localparam logic [9:0] ARB_FIXED_MASK =
        (10'b1 << PIN_CONFIG_CLK) | (10'b1 << PIN_BXCLK_ANA) | (10'b1 << PIN_BXCLK);

    // Firmware IDs as seen on fw_dev_id_enable; zero means no owner
    localparam logic [3:0] firmware_id_none = 4'd0;
    localparam logic [3:0] firmware_id_1    = 4'd1;
    localparam logic [3:0] firmware_id_2    = 4'd2;
    localparam logic [3:0] firmware_id_3    = 4'd3;
    localparam logic [3:0] firmware_id_4    = 4'd4;

endpackage

// File: rtl/com_in_sync.sv
// rtl/com_in_sync.sv - multi-bit input synchroniser chain, first stage is the IOB FF
module com_in_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             iob_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_sync
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the pin samples down the chain, cleared on reset
    always_ff @(posedge iob_clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain[0] <= pin_in;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

    assign pin_sync = chain[STAGES-1];

endmodule

// File: rtl/com_fw_to_dut_arb.sv
// rtl/com_fw_to_dut_arb.sv - guarded arbiter of firmware IPs onto the DUT pins
module com_fw_to_dut_arb
    import com_fw_to_dut_arb_pkg::*;
#(
    parameter int                       NUM_FW         = 4,
    parameter int                       NUM_OUT        = 10,
    parameter int                       NUM_IN         = 5,
    parameter int                       GUARD_CYCLES   = 8,
    parameter int                       IN_SYNC_STAGES = 2,
    parameter logic [NUM_OUT-1:0]       OUT_DEFAULT    = ARB_OUT_DEFAULT,
    parameter logic [NUM_OUT-1:0]       FIXED_MASK     = ARB_FIXED_MASK,
    parameter logic [NUM_OUT*4-1:0]     FIXED_SEL      = {NUM_OUT{4'd1}}
) (
    input  logic                            iob_clk,
    input  logic                            reset,
    input  logic [3:0]                      fw_dev_id_enable,
    input  logic [NUM_FW-1:0][NUM_OUT-1:0]  fw_out,
    output logic [NUM_FW-1:0][NUM_IN-1:0]   fw_in,
    output logic [NUM_OUT-1:0]              dut_out,
    input  logic [NUM_IN-1:0]               dut_in,
    output logic [3:0]                      owner,
    output logic                            switch_busy,
    output logic                            id_illegal,
    output logic [7:0]                      switch_count
);

    localparam logic [3:0] NUM_FW_ID  = 4'(NUM_FW);
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    arb_state_t          state, state_nxt;
    logic [3:0]          id_reg;
    logic [3:0]          target, target_nxt;
    logic [3:0]          owner_nxt;
    logic [7:0]          guard_cnt, guard_cnt_nxt;
    logic                count_inc;
    logic                valid;
    logic                owner_live;
    logic [NUM_OUT-1:0]  arb_pins;
    logic [NUM_OUT-1:0]  fixed_pins;
    logic [NUM_OUT-1:0]  pin_nxt;
    logic [NUM_IN-1:0]   sync_out;

    assign valid       = (id_reg != firmware_id_none) && (id_reg <= NUM_FW_ID);
    assign switch_busy = (state == GUARD);

    // The owner only drives while its ID is still requested; a mismatch drops
    // the pins to defaults in the same cycle the FSM decides to leave ACTIVE.
    assign owner_live  = (state == ACTIVE) && (id_reg == owner);

    com_in_sync #(
        .WIDTH  (NUM_IN),
        .STAGES (IN_SYNC_STAGES)
    ) u_in_sync (
        .iob_clk  (iob_clk),
        .reset    (reset),
        .pin_in   (dut_in),
        .pin_sync (sync_out)
    );

    // Next-state logic of the guarded switchover
    always_comb begin
        state_nxt     = state;
        target_nxt    = target;
        guard_cnt_nxt = guard_cnt;
        owner_nxt     = owner;
        count_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt     = GUARD;
                    target_nxt    = id_reg;
                    guard_cnt_nxt = GUARD_LOAD;
                end
            end
            GUARD: begin
                if (id_reg != target) begin
                    if (valid) begin
                        target_nxt    = id_reg;
                        guard_cnt_nxt = GUARD_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (guard_cnt == 8'd0) begin
                    state_nxt = ACTIVE;
                    owner_nxt = target;
                    count_inc = 1'b1;
                end else begin
                    guard_cnt_nxt = guard_cnt - 8'd1;
                end
            end
            ACTIVE: begin
                if (id_reg != owner) begin
                    owner_nxt = firmware_id_none;
                    if (valid) begin
                        state_nxt     = GUARD;
                        target_nxt    = id_reg;
                        guard_cnt_nxt = GUARD_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = firmware_id_none;
            end
        endcase
    end

    // Arbitrated pin values: owner's request while live, safe defaults otherwise
    always_comb begin
        arb_pins = OUT_DEFAULT;
        for (int k = 0; k < NUM_FW; k++) begin
            if (owner_live && (owner == 4'(k + 1))) begin
                arb_pins = fw_out[k];
            end
        end
    end

    // Dedicated pins follow their fixed firmware IP regardless of ownership
    always_comb begin
        fixed_pins = OUT_DEFAULT;
        for (int i = 0; i < NUM_OUT; i++) begin
            for (int k = 0; k < NUM_FW; k++) begin
                if (FIXED_SEL[i*4 +: 4] == 4'(k)) begin
                    fixed_pins[i] = fw_out[k][i];
                end
            end
        end
    end

    assign pin_nxt = (fixed_pins & FIXED_MASK) | (arb_pins & ~FIXED_MASK);

    // State registers, IOB output FFs, status and per-FW input view
    always_ff @(posedge iob_clk) begin
        if (reset) begin
            state        <= IDLE;
            id_reg       <= firmware_id_none;
            target       <= firmware_id_none;
            guard_cnt    <= '0;
            owner        <= firmware_id_none;
            id_illegal   <= 1'b0;
            switch_count <= '0;
            dut_out      <= OUT_DEFAULT;
            fw_in        <= '0;
        end else begin
            state      <= state_nxt;
            id_reg     <= fw_dev_id_enable;
            target     <= target_nxt;
            guard_cnt  <= guard_cnt_nxt;
            owner      <= owner_nxt;
            id_illegal <= !valid;
            dut_out    <= pin_nxt;
            if (count_inc && (switch_count != 8'hFF)) begin
                switch_count <= switch_count + 8'd1;
            end
            fw_in <= '0;
            for (int k = 0; k < NUM_FW; k++) begin
                if (owner_live && (owner == 4'(k + 1))) begin
                    fw_in[k] <= sync_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_com_fw_to_dut_arb.sv
// tb/tb_com_fw_to_dut_arb.sv - directed self-checking bench for com_fw_to_dut_arb
module tb_com_fw_to_dut_arb;

    localparam logic [9:0] DEF   = 10'b0000010100;
    localparam logic [9:0] FMASK = 10'b0001100010;

    logic             iob_clk = 1'b0;
    logic             reset;
    logic [3:0]       fw_dev_id_enable;
    logic [3:0][9:0]  fw_out;
    logic [3:0][4:0]  fw_in;
    logic [9:0]       dut_out;
    logic [4:0]       dut_in;
    logic [3:0]       owner;
    logic             switch_busy;
    logic             id_illegal;
    logic [7:0]       switch_count;

    int total = 0;
    int bad   = 0;

    com_fw_to_dut_arb dut (
        .iob_clk          (iob_clk),
        .reset            (reset),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_out           (fw_out),
        .fw_in            (fw_in),
        .dut_out          (dut_out),
        .dut_in           (dut_in),
        .owner            (owner),
        .switch_busy      (switch_busy),
        .id_illegal       (id_illegal),
        .switch_count     (switch_count)
    );

    always #5 iob_clk = ~iob_clk;

    task automatic tick();
        @(posedge iob_clk);
        #1;
    endtask

    // Expected pins: arbitrated part given, fixed part from fw_out[1]
    function automatic logic [9:0] exp_pins(input logic [9:0] arb);
        return (arb & ~FMASK) | (fw_out[1] & FMASK);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        fw_dev_id_enable = 4'd0;
        fw_out = '0;
        fw_out[1] = 10'h3FF;
        dut_in = 5'h1F;
        tick();
        tick();
        total++; if (dut_out !== DEF) begin bad++; $display("FAIL reset_dut_out got=%h exp=%h", dut_out, DEF); end
        total++; if (owner !== 4'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", switch_busy); end
        total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", id_illegal); end
        total++; if (switch_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", switch_count); end
        total++; if (fw_in !== 20'd0) begin bad++; $display("FAIL reset_fw_in got=%h exp=0", fw_in); end
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_first_owner();
        logic [9:0] e;
        fw_out[0] = 10'h3FF;
        fw_out[1] = 10'h000;
        fw_out[2] = 10'h155;
        fw_out[3] = 10'h2AA;
        fw_dev_id_enable = 4'd1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e = (k <= 10) ? exp_pins(DEF) : exp_pins(10'h3FF);
            total++; if (dut_out !== e) begin bad++; $display("FAIL first_dut_out k=%0d got=%h exp=%h", k, dut_out, e); end
            total++; if (switch_busy !== (k >= 2 && k <= 9)) begin bad++; $display("FAIL first_busy k=%0d got=%b", k, switch_busy); end
            total++; if (owner !== ((k >= 10) ? 4'd1 : 4'd0)) begin bad++; $display("FAIL first_owner k=%0d got=%0d", k, owner); end
        end
        total++; if (switch_count !== 8'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", switch_count); end
    endtask

    task automatic test_switch();
        logic [9:0]      e;
        logic [3:0][4:0] ef;
        logic [3:0]      eo;
        dut_in = 5'h15;
        tick(); tick(); tick(); tick();
        ef = '0; ef[0] = 5'h15;
        total++; if (fw_in !== ef) begin bad++; $display("FAIL switch_fw_in_owner1 got=%h exp=%h", fw_in, ef); end
        fw_out[1] = 10'h3C9;
        fw_dev_id_enable = 4'd2;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1)       e = exp_pins(10'h3FF);
            else if (k <= 10) e = exp_pins(DEF);
            else              e = exp_pins(10'h3C9);
            total++; if (dut_out !== e) begin bad++; $display("FAIL switch_dut_out k=%0d got=%h exp=%h", k, dut_out, e); end
            total++; if (switch_busy !== (k >= 2 && k <= 9)) begin bad++; $display("FAIL switch_busy k=%0d got=%b", k, switch_busy); end
            eo = (k == 1) ? 4'd1 : ((k >= 10) ? 4'd2 : 4'd0);
            total++; if (owner !== eo) begin bad++; $display("FAIL switch_owner k=%0d got=%0d exp=%0d", k, owner, eo); end
            ef = '0;
            if (k == 1)  ef[0] = 5'h15;
            if (k == 11) ef[1] = 5'h15;
            total++; if (fw_in !== ef) begin bad++; $display("FAIL switch_fw_in k=%0d got=%h exp=%h", k, fw_in, ef); end
        end
        dut_in = 5'h0A;
        for (int k = 1; k <= 3; k++) begin
            tick();
            ef = '0;
            ef[1] = (k < 3) ? 5'h15 : 5'h0A;
            total++; if (fw_in !== ef) begin bad++; $display("FAIL switch_in_latency k=%0d got=%h exp=%h", k, fw_in, ef); end
        end
        total++; if (switch_count !== 8'd2) begin bad++; $display("FAIL switch_count got=%0d exp=2", switch_count); end
    endtask

    task automatic test_restart();
        logic [9:0] e;
        fw_dev_id_enable = 4'd0;
        tick(); tick(); tick(); tick();
        fw_dev_id_enable = 4'd2;
        for (int k = 1; k <= 19; k++) begin
            tick();
            e = (k <= 18) ? exp_pins(DEF) : exp_pins(10'h155);
            total++; if (dut_out !== e) begin bad++; $display("FAIL restart_dut_out k=%0d got=%h exp=%h", k, dut_out, e); end
            total++; if (switch_busy !== (k >= 2 && k <= 17)) begin bad++; $display("FAIL restart_busy k=%0d got=%b", k, switch_busy); end
            total++; if (owner !== ((k >= 18) ? 4'd3 : 4'd0)) begin bad++; $display("FAIL restart_owner k=%0d got=%0d", k, owner); end
            total++; if (switch_count !== ((k >= 18) ? 8'd3 : 8'd2)) begin bad++; $display("FAIL restart_count k=%0d got=%0d", k, switch_count); end
            if (k == 8) fw_dev_id_enable = 4'd3;
        end
    endtask

    task automatic test_illegal();
        fw_dev_id_enable = 4'd7;
        tick();
        total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL illegal_lag got=%b exp=0", id_illegal); end
        tick();
        total++; if (id_illegal !== 1'b1) begin bad++; $display("FAIL illegal_7 got=%b exp=1", id_illegal); end
        tick();
        total++; if (owner !== 4'd0) begin bad++; $display("FAIL illegal_7_owner got=%0d exp=0", owner); end
        total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL illegal_7_busy got=%b exp=0", switch_busy); end
        total++; if (dut_out !== exp_pins(DEF)) begin bad++; $display("FAIL illegal_7_dut_out got=%h exp=%h", dut_out, exp_pins(DEF)); end
        fw_dev_id_enable = 4'd0;
        fw_out[1] = 10'h000;
        tick(); tick(); tick();
        total++; if (id_illegal !== 1'b1) begin bad++; $display("FAIL illegal_0 got=%b exp=1", id_illegal); end
        total++; if (owner !== 4'd0) begin bad++; $display("FAIL illegal_0_owner got=%0d exp=0", owner); end
        total++; if (dut_out !== (DEF & ~FMASK)) begin bad++; $display("FAIL illegal_0_dut_out got=%h exp=%h", dut_out, DEF & ~FMASK); end
        fw_out[1] = 10'h3FF;
        tick();
        total++; if (dut_out !== (DEF | FMASK)) begin bad++; $display("FAIL fixed_rise got=%h exp=%h", dut_out, DEF | FMASK); end
        fw_out[1] = 10'h000;
        tick();
        total++; if (dut_out !== (DEF & ~FMASK)) begin bad++; $display("FAIL fixed_fall got=%h exp=%h", dut_out, DEF & ~FMASK); end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        exp_cnt = 3;
        for (int n = 0; n < 300; n++) begin
            fw_dev_id_enable = (n % 2 == 0) ? 4'd1 : 4'd2;
            for (int c = 0; c < 12; c++) tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (n == 99) begin
                total++; if (switch_count !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_mid got=%0d exp=%0d", switch_count, exp_cnt); end
            end
        end
        total++; if (switch_count !== 8'd255) begin bad++; $display("FAIL sat_end got=%0d exp=255", switch_count); end
        total++; if (owner !== 4'd2) begin bad++; $display("FAIL sat_owner got=%0d exp=2", owner); end
        total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL sat_illegal got=%b exp=0", id_illegal); end
    endtask

    task automatic test_reset_mid();
        fw_out[1] = 10'h3FF;
        dut_in = 5'h1B;
        fw_dev_id_enable = 4'd1;
        tick(); tick(); tick(); tick();
        total++; if (switch_busy !== 1'b1) begin bad++; $display("FAIL rst_guard_pre got=%b exp=1", switch_busy); end
        reset = 1'b1;
        tick();
        total++; if (dut_out !== DEF) begin bad++; $display("FAIL rst_guard_dut_out got=%h exp=%h", dut_out, DEF); end
        total++; if (owner !== 4'd0) begin bad++; $display("FAIL rst_guard_owner got=%0d exp=0", owner); end
        total++; if (switch_count !== 8'd0) begin bad++; $display("FAIL rst_guard_count got=%0d exp=0", switch_count); end
        total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL rst_guard_busy got=%b exp=0", switch_busy); end
        total++; if (fw_in !== 20'd0) begin bad++; $display("FAIL rst_guard_fw_in got=%h exp=0", fw_in); end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL rst_discard_busy got=%b exp=0", switch_busy); end
            end
            if (k == 9) begin
                total++; if (owner !== 4'd0) begin bad++; $display("FAIL rst_regrant_early got=%0d exp=0", owner); end
            end
        end
        total++; if (owner !== 4'd1) begin bad++; $display("FAIL rst_regrant_owner got=%0d exp=1", owner); end
        total++; if (switch_count !== 8'd1) begin bad++; $display("FAIL rst_regrant_count got=%0d exp=1", switch_count); end
        tick(); tick(); tick(); tick();
        total++; if (fw_in[0] !== 5'h1B) begin bad++; $display("FAIL rst_active_pre got=%h exp=1b", fw_in[0]); end
        reset = 1'b1;
        tick();
        total++; if (dut_out !== DEF) begin bad++; $display("FAIL rst_active_dut_out got=%h exp=%h", dut_out, DEF); end
        total++; if (owner !== 4'd0) begin bad++; $display("FAIL rst_active_owner got=%0d exp=0", owner); end
        total++; if (switch_count !== 8'd0) begin bad++; $display("FAIL rst_active_count got=%0d exp=0", switch_count); end
        total++; if (fw_in !== 20'd0) begin bad++; $display("FAIL rst_active_fw_in got=%h exp=0", fw_in); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_owner();
        test_switch();
        test_restart();
        test_illegal();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/com_fw_to_dut_arb.md
Name: com_fw_to_dut_arb

Overview:
- Parametrised successor of the firmware-to-DUT pin multiplexer.
- Arbitrates NUM_FW firmware IPs onto one set of DUT pins through output IOB FFs and input synchroniser chains.
- Adds a guarded switchover state machine: DUT pins are held at safe defaults for GUARD_CYCLES whenever ownership changes.
- Adds status reporting (current owner, busy flag, illegal-ID flag, switch counter). Sits between the fw_ip* instances and the FPGA pins.

Parameters:
- NUM_FW, 4: number of firmware IPs; 1..15.
- NUM_OUT, 10: DUT output pins.
- NUM_IN, 5: DUT input pins.
- GUARD_CYCLES, 8: iob_clk cycles of forced defaults on an owner change; 1..255.
- IN_SYNC_STAGES, 2: input FF chain depth; the first stage is the IOB FF; 1..4.
- OUT_DEFAULT, 10'b0000010100: per-pin safe value; reset_not=1, config_load=1.
- FIXED_MASK, 10'b0001100010: pins with a dedicated owner that bypass arbitration (config_clk, bxclk_ana, bxclk).
- FIXED_SEL, packed NUM_OUT x 4 bits: dedicated FW index for each pin in FIXED_MASK.

Ports:
- iob_clk  in  1: 400 MHz pin clock.
- reset  in  1: synchronous, active-high.
- fw_dev_id_enable  in  4: requested owner ID; k+1 selects fw index k.
- fw_out  in  NUM_FW x NUM_OUT: per-FW pin drive requests.
- fw_in  out  NUM_FW x NUM_IN: per-FW view of the DUT inputs.
- dut_out  out  NUM_OUT: to the FPGA output pins.
- dut_in  in  NUM_IN: from the FPGA input pins.
- owner  out  4: active owner ID; 0 = none.
- switch_busy  out  1: guard interval in progress.
- id_illegal  out  1: requested ID is 0 or greater than NUM_FW.
- switch_count  out  8: count of completed switchovers, saturating.

Behaviour:
- Reset values: dut_out=OUT_DEFAULT; owner=0; switch_busy=0; id_illegal=0; switch_count=0; fw_in=0; synchroniser chains=0; state=IDLE.
- id_reg registers fw_dev_id_enable each cycle. All decisions use id_reg, so they lag the input by one cycle. valid = id_reg in 1..NUM_FW.
- id_illegal is registered from (!valid).
- IDLE:
  - Arbitrated pins = OUT_DEFAULT.
  - valid -> GUARD, load target=id_reg, guard_cnt=GUARD_CYCLES-1.
- GUARD:
  - Arbitrated pins = OUT_DEFAULT; owner=0; switch_busy=1.
  - id_reg != target: if valid, reload target and guard_cnt; if not valid -> IDLE.
  - Otherwise, guard_cnt==0 -> ACTIVE, owner=target, switch_count+1 saturating at 255. Else guard_cnt-1.
- ACTIVE:
  - Arbitrated pins = fw_out[owner-1]; switch_busy=0.
  - id_reg != owner: if valid -> GUARD with the new target, owner=0; else -> IDLE, owner=0.
- Fixed pins (FIXED_MASK=1) always carry fw_out[FIXED_SEL[i]][i] in every state, including IDLE and GUARD. Their only deviation is OUT_DEFAULT while reset is asserted.
- Output path: the mux is combinational from registered state, then the IOB FF. Latency fw_out -> dut_out = 1 cycle in ACTIVE.
- Input path:
  - dut_in passes through IN_SYNC_STAGES FFs.
  - fw_in[owner-1] = sync output, registered; latency = IN_SYNC_STAGES+1 cycles.
  - All other fw_in rows = 0. All rows are 0 when state != ACTIVE.
- Duration: an ID change leaves arbitrated pins at OUT_DEFAULT for exactly GUARD_CYCLES+1 cycles, from the first default cycle to the first cycle of new-owner drive.
- Simultaneous events:
  - reset overrides everything.
  - An ID change on the final guard cycle restarts the guard; switch_count is not incremented.
  - Returning to the original owner during GUARD still completes the guard and counts.
- Reset mid-operation: in the next cycle all outputs are at reset values and any pending switch is discarded.

Decomposition:
- cms_pix28_package additions:
  - typedef enum {IDLE, GUARD, ACTIVE} arb_state_t
  - localparams PIN_SUPER_PIXEL_SEL..PIN_SCAN_LOAD (output bit indices), PIN_CONFIG_OUT..PIN_DN_EVENT_TOGGLE (input bit indices)
  - default OUT_DEFAULT / FIXED_MASK constants
  - existing firmware_id_* reused as the valid ID values
- One sub-module: com_in_sync. It is a parametrised NUM_IN x IN_SYNC_STAGES FF chain with synchronous reset, instantiated once.

Test Plan:
- Reset, then ID=1, fw_out[0]=10'h3FF, GUARD_CYCLES=8: dut_out=OUT_DEFAULT on arbitrated pins for 9 cycles, then 10'h3FF. owner=1, switch_count=1.
- ACTIVE owner 1, switch ID 1->2: switch_busy=1 for 8 cycles, all fw_in rows 0 during the guard, then fw_in[1] tracks dut_in with latency 3 and fw_in[0]=0. switch_count=2.
- During GUARD, ID 2->3 on guard_cnt==0: the guard restarts, giving a 9-cycle default window for owner 3. switch_count increments once only.
- ID=0 or ID=7 with NUM_FW=4: id_illegal=1, state IDLE, arbitrated pins = OUT_DEFAULT. Fixed pins still follow fw_out[1] (bxclk toggle visible with 1-cycle latency).
- 300 alternating switches with guards completed: switch_count saturates at 255.
- reset asserted mid-GUARD and mid-ACTIVE: on the next cycle dut_out=OUT_DEFAULT, owner=0, switch_count=0, fw_in=0.
